// File: rtl/sar_search.sv
// Successive-approximation search: drives a candidate to an external comparator
// and narrows [lo,hi] one comparison at a time until equality, exhaustion or bad flags.
module sar_search #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       iters
);

  // state | meaning
  // IDLE  | waiting for start; outputs hold the last search
  // WAIT  | guess settling at the comparator; flags sampled when wcnt==1
  // DONE  | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

  localparam logic [WIDTH:0]   MAXV     = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   ONE      = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   FIRSTEXT = MAXV >> 1;
  localparam logic [WIDTH-1:0] FIRST    = FIRSTEXT[WIDTH-1:0];
  localparam logic [3:0]       SETTLECNT = 4'(SETTLE);

  stateT          state;
  logic [WIDTH:0] lo;
  logic [WIDTH:0] hi;
  logic [3:0]     wcnt;

  // Bounds and midpoints are carried one bit wider so lo+hi never overflows.
  logic [WIDTH:0] guessExt;
  logic [WIDTH:0] hiDec;
  logic [WIDTH:0] loInc;
  logic [WIDTH:0] sumGt;
  logic [WIDTH:0] sumLt;
  logic           flagsValid;
  logic           atMax;

  assign guessExt   = {1'b0, guess};
  assign hiDec      = guessExt - ONE;
  assign loInc      = guessExt + ONE;
  assign sumGt      = lo + hiDec;
  assign sumLt      = loInc + hi;
  assign atMax      = (guessExt == MAXV);
  assign flagsValid = ( cmp_eq & ~cmp_gt & ~cmp_lt) |
                      (~cmp_eq &  cmp_gt & ~cmp_lt) |
                      (~cmp_eq & ~cmp_gt &  cmp_lt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      wcnt   <= '0;
      guess  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      iters  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lo    <= '0;
            hi    <= MAXV;
            guess <= FIRST;
            wcnt  <= SETTLECNT;
            iters <= '0;
            found <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt == 4'd1) begin
            iters <= iters + 5'd1;
            if (!flagsValid) begin
              err   <= 1'b1;
              found <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else if (cmp_eq) begin
              result <= guess;
              found  <= 1'b1;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else if (cmp_gt) begin
              hi <= hiDec;
              // guess==0 makes hiDec wrap, so it is tested before the range check
              if (guess == '0 || lo > hiDec) begin
                found <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                guess <= WIDTH'(sumGt >> 1);
                wcnt  <= SETTLECNT;
              end
            end else begin
              lo <= loInc;
              if (atMax || loInc > hi) begin
                found <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                guess <= WIDTH'(sumLt >> 1);
                wcnt  <= SETTLECNT;
              end
            end
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the search operand width in bits (range 2..16).
REQ-002 SHALL have parameter SETTLE, default 1, giving the cycles guess is held stable before the external comparator flags are sampled (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: request a new search; accepted only in IDLE.
REQ-006 SHALL have port guess, output, WIDTH bits: registered candidate value driven to the external comparator A operand.
REQ-007 SHALL have ports cmp_eq, cmp_gt and cmp_lt, inputs, 1 bit each: comparator flags meaning guess==target, guess>target and guess<target.
REQ-008 SHALL have port busy, output, 1 bit: high while a search is in progress.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse marking search completion.
REQ-010 SHALL have port found, output, 1 bit: set when the completed search hit equality.
REQ-011 SHALL have port err, output, 1 bit: set when the completed search aborted on invalid flags.
REQ-012 SHALL have port result, output, WIDTH bits: the matched value, valid when found=1.
REQ-013 SHALL have port iters, output, 5 bits: the number of comparisons the last search used.

Function
REQ-014 SHALL implement three states: IDLE, WAIT and DONE.
REQ-015 In IDLE, start=1 at a clock edge SHALL set lo=0, hi=2^WIDTH-1, guess=(lo+hi)>>1, wcnt=SETTLE, iters=0, clear found and err, set busy, and enter WAIT.
REQ-016 lo/hi/sum arithmetic SHALL be done at WIDTH+1 bits so that it cannot overflow.
REQ-017 In WAIT, wcnt SHALL decrement each cycle, and the flags SHALL be sampled only at the edge where wcnt==1, giving exactly SETTLE cycles per comparison.
REQ-018 At the sample edge, iters SHALL increment by 1.
REQ-019 At the sample edge, if the flags are not exactly one-hot, err=1, found=0 and the state goes to DONE.
REQ-020 At the sample edge, cmp_eq=1 SHALL set result=guess, found=1 and go to DONE.
REQ-021 At the sample edge, cmp_gt=1 SHALL set hi=guess-1; if guess==0 or lo>hi, found=0 and go to DONE; otherwise guess=(lo+hi)>>1, wcnt=SETTLE, and stay in WAIT.
REQ-022 At the sample edge, cmp_lt=1 SHALL set lo=guess+1; if guess==2^WIDTH-1 or lo>hi, found=0 and go to DONE; otherwise compute the new guess as for cmp_gt.
REQ-023 In DONE, done=1 and busy=0 for exactly one cycle, then the state SHALL return to IDLE unconditionally.
REQ-024 start SHALL be ignored in WAIT and DONE, and a start held high across DONE SHALL launch a new search from IDLE on the following edge.
REQ-025 guess, result, found, err and iters SHALL hold their values in IDLE until the next accepted start.
REQ-026 A full-range search SHALL terminate in at most WIDTH+1 comparisons.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE and guess=0, busy=0, done=0, found=0, err=0, result=0, iters=0, independent of clk.
REQ-028 Reset asserted mid-search SHALL abandon the search with no done pulse.
REQ-029 After reset is released, the first start SHALL behave as in REQ-015.

Verification (WIDTH=8, SETTLE=1, behavioural comparator model with a hidden target unless stated)
REQ-030 The bench SHALL cover: target 0x7F, start pulse -> guess=0x7F one cycle after the start edge; done pulse on the next cycle; found=1, result=0x7F, iters=1.
REQ-031 The bench SHALL cover: target 0xFF -> guesses 7F,BF,DF,EF,F7,FB,FD,FE,FF; found=1, result=0xFF, iters=9.
REQ-032 The bench SHALL cover: target 0x00 -> guesses 7F,3F,1F,0F,07,03,01,00; found=1, iters=8; then repeat with SETTLE=3 -> each guess held 3 cycles.
REQ-033 The bench SHALL cover: comparator stuck at cmp_gt=1 -> guess reaches 0x00; done with found=0, err=0, iters=8.
REQ-034 The bench SHALL cover: flags 000 on the first sample -> done with err=1, found=0, iters=1; flags 110 -> same response.
REQ-035 The bench SHALL cover: rst_n pulsed low during the third comparison -> all outputs 0 asynchronously, no done pulse; start pulses while busy -> ignored, with guess sequence unchanged.
